// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - character codes, default message and scroller state type
package msg_pkg;

    localparam int CHAR_W = 5;

    localparam logic [CHAR_W-1:0] CHAR_0     = 5'd0;
    localparam logic [CHAR_W-1:0] CHAR_E     = 5'd14;
    localparam logic [CHAR_W-1:0] CHAR_H     = 5'd16;
    localparam logic [CHAR_W-1:0] CHAR_L     = 5'd17;
    localparam logic [CHAR_W-1:0] CHAR_P     = 5'd18;
    localparam logic [CHAR_W-1:0] CHAR_U     = 5'd19;
    localparam logic [CHAR_W-1:0] CHAR_R     = 5'd20;
    localparam logic [CHAR_W-1:0] CHAR_N     = 5'd21;
    localparam logic [CHAR_W-1:0] CHAR_O     = 5'd22;
    localparam logic [CHAR_W-1:0] CHAR_DASH  = 5'd23;
    localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'd31;

    // "HELLO" with the O drawn as the digit 0 glyph; character k sits at [k*CHAR_W +: CHAR_W]
    localparam int DEFAULT_LEN = 5;
    localparam logic [DEFAULT_LEN*CHAR_W-1:0] DEFAULT_MSG = {CHAR_0, CHAR_L, CHAR_L, CHAR_E, CHAR_H};

    typedef enum logic [1:0] {
        SCROLL = 2'd0,
        DWELL  = 2'd1,
        HOLD   = 2'd2
    } scroll_state_e;

    function automatic logic [CHAR_W-1:0] default_char(input int idx);
        if (idx < DEFAULT_LEN) begin
            return DEFAULT_MSG[idx*CHAR_W +: CHAR_W];
        end
        return CHAR_BLANK;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - character code to active-low seven-segment pattern (g..a)
module seg_decoder
    import msg_pkg::*;
(
    input  logic [CHAR_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (code_i)
            5'd0:  seg_o = 7'h40;
            5'd1:  seg_o = 7'h79;
            5'd2:  seg_o = 7'h24;
            5'd3:  seg_o = 7'h30;
            5'd4:  seg_o = 7'h19;
            5'd5:  seg_o = 7'h12;
            5'd6:  seg_o = 7'h02;
            5'd7:  seg_o = 7'h78;
            5'd8:  seg_o = 7'h00;
            5'd9:  seg_o = 7'h10;
            5'd10: seg_o = 7'h08;
            5'd11: seg_o = 7'h03;
            5'd12: seg_o = 7'h46;
            5'd13: seg_o = 7'h21;
            5'd14: seg_o = 7'h06;
            5'd15: seg_o = 7'h0E;
            5'd16: seg_o = 7'h09;
            5'd17: seg_o = 7'h47;
            5'd18: seg_o = 7'h0C;
            5'd19: seg_o = 7'h41;
            5'd20: seg_o = 7'h2F;
            5'd21: seg_o = 7'h2B;
            5'd22: seg_o = 7'h23;
            5'd23: seg_o = 7'h3F;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/message_scroller.sv
// rtl/message_scroller.sv - sliding six-digit window over a writable circular message buffer
module message_scroller
    import msg_pkg::*;
#(
    parameter int MSG_LEN     = 16,
    parameter int NUM_DIGITS  = 6,
    parameter int DWELL_STEPS = 2
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        scroll_clk,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [CHAR_W-1:0]           wr_char,
    output logic [7*NUM_DIGITS-1:0]     hex_out,
    output logic [$clog2(MSG_LEN)-1:0]  pos,
    output logic                        step_pulse
);

    localparam int AW = $clog2(MSG_LEN);

    logic [CHAR_W-1:0]       msg_q [MSG_LEN];
    logic                    prev_q;
    logic [AW-1:0]           pos_q;
    scroll_state_e           state_q;
    logic [7:0]              dwell_cnt_q;
    logic                    step_q;
    logic [7*NUM_DIGITS-1:0] hex_q;

    logic                    tick;
    logic                    tick_ok;
    logic [AW-1:0]           pos_d;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic [CHAR_W-1:0]       win_char [NUM_DIGITS];

    assign tick    = scroll_clk & ~prev_q;
    // a write in the same cycle swallows the tick
    assign tick_ok = tick & ~wr_en;

    always_comb begin
        pos_d = pos_q;
        if (dir) begin
            pos_d = (pos_q == '0) ? AW'(MSG_LEN - 1) : pos_q - 1'b1;
        end else begin
            pos_d = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prev_q      <= 1'b0;
            pos_q       <= '0;
            state_q     <= SCROLL;
            dwell_cnt_q <= '0;
            step_q      <= 1'b0;
        end else begin
            prev_q <= scroll_clk;
            step_q <= 1'b0;
            if (!run) begin
                state_q     <= HOLD;
                dwell_cnt_q <= '0;
            end else begin
                case (state_q)
                    SCROLL: begin
                        if (tick_ok) begin
                            pos_q  <= pos_d;
                            step_q <= 1'b1;
                            if (pos_d == '0 && DWELL_STEPS > 0) begin
                                state_q     <= DWELL;
                                dwell_cnt_q <= '0;
                            end
                        end
                    end
                    DWELL: begin
                        if (tick_ok) begin
                            if (dwell_cnt_q == 8'(DWELL_STEPS - 1)) begin
                                state_q     <= SCROLL;
                                dwell_cnt_q <= '0;
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: state_q <= SCROLL;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= default_char(i);
            end
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_char;
        end
    end

    // digit NUM_DIGITS-1 (leftmost) shows buf[pos]
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign win_char[g] = msg_q[AW'((int'(pos_q) + NUM_DIGITS - 1 - g) % MSG_LEN)];
        seg_decoder u_dec (
            .code_i (win_char[g]),
            .seg_o  (seg_d[7*g +: 7])
        );
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            hex_q <= '1;
        end else begin
            hex_q <= seg_d;
        end
    end

    assign hex_out    = hex_q;
    assign pos        = pos_q;
    assign step_pulse = step_q;

endmodule

// File: doc/message_scroller.md
# message_scroller

Consumes the divided scroll clock from the clock divider and drives the six-digit seven-segment display with a sliding window over a writable circular message buffer. Each rising edge of the scroll clock advances the window by one character, left or right. Scrolling can be paused, and the window dwells briefly at the start of the message on each wrap. Sits directly downstream of the clock divider and feeds the HEX display pins.

## Interface
- MSG_LEN, 16: message buffer depth in characters (≥ NUM_DIGITS).
- NUM_DIGITS, 6: number of display digits.
- DWELL_STEPS, 2: scroll ticks held at position 0 after arriving there; 0 disables the dwell.
- clk_in  in  1  system clock; scroll_clk is synchronous to it.
- reset  in  1  synchronous, active-high.
- scroll_clk  in  1  divided clock from the clock divider, sampled as data.
- run  in  1  1 = scroll, 0 = hold.
- dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos−1).
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  $clog2(MSG_LEN)  buffer write address.
- wr_char  in  5  character code to write.
- hex_out  out  7*NUM_DIGITS  active-low segments per digit, bit order g..a; digit 0 at [6:0] (rightmost).
- pos  out  $clog2(MSG_LEN)  buffer index shown on the leftmost digit.
- step_pulse  out  1  one-cycle pulse each time pos moves.

## Operation
- Edge detect: `prev` register holds scroll_clk. `tick` = scroll_clk & ~prev. No synchroniser is used; the input is same-domain.
- Window: digit NUM_DIGITS−1−i shows buf[(pos+i) mod MSG_LEN] for i = 0..NUM_DIGITS−1.
- Character codes:
  - 0–9: digits.
  - 10–15: A–F.
  - 16 H, 17 L, 18 P, 19 U, 20 r, 21 n, 22 o, 23 dash.
  - 31: blank. All other codes decode as blank.
- FSM states: SCROLL, DWELL, HOLD.
  - SCROLL, tick: pos moves one step per dir, mod MSG_LEN, wrapping 15↔0. step_pulse is asserted. If the new pos is 0 and DWELL_STEPS > 0, go to DWELL with dwell_cnt = 0.
  - DWELL, tick: pos does not move. dwell_cnt increments. On the tick where dwell_cnt == DWELL_STEPS−1, return to SCROLL; that tick is consumed without a move.
  - Any state with run = 0: go to HOLD, clear dwell_cnt. Ticks are discarded, not queued.
  - HOLD with run = 1: go to SCROLL.
- Write: when wr_en = 1, buf[wr_addr] ← wr_char. A tick in the same cycle is discarded (no move, no dwell count). Writes are accepted in every state.
- Reset:
  - buf ← DEFAULT_MSG.
  - pos = 0, state SCROLL, dwell_cnt = 0, prev = 0.
  - step_pulse = 0, hex_out = all ones (blank).

## Timing
- Edge N samples scroll_clk = 1 with prev = 0. pos and step_pulse update at edge N; step_pulse is high for exactly the following cycle.
- hex_out is a registered decode. It reflects a pos or buffer change one edge later (N+1).
- A scroll_clk that is high for many cycles produces exactly one tick.
- A write at edge N is visible on hex_out after edge N+1.
- First valid display: edge 1 after reset deasserts.
- Reset mid-DWELL or mid-HOLD returns to the reset state on the next edge. A buffer write pending in that cycle is lost.

## Structure
- Package `msg_pkg` holds:
  - CHAR_W = 5.
  - Character code constants (CHAR_BLANK = 31, CHAR_DASH = 23, …).
  - DEFAULT_MSG: H,E,L,L,O, followed by blanks.
  - State enum {SCROLL, DWELL, HOLD}.
- Sub-module `seg_decoder`: combinational 5-bit code to 7-bit active-low segments. Instantiate it NUM_DIGITS times, with registers in the parent.

## Test plan
All scenarios use default parameters. Segment values are active low, bit order g..a.
- Reset, release, wait 2 cycles -> HEX5..HEX0 = 0x09 (H), 0x06 (E), 0x47 (L), 0x47 (L), 0x40 (O), 0x7F (blank); pos = 0.
- scroll_clk high for 3 cycles, run = 1, dir = 0 -> one step_pulse; pos = 1; HEX5 = 0x06 one cycle after the pulse.
- 16 ticks left from pos 0 -> pos wraps 15→0. The next 2 ticks give no move and no step_pulse. The 3rd tick moves to pos = 1.
- dir = 1 at pos 1 -> pos 0, then DWELL (2 ticks). Next tick -> pos 15, HEX5 = 0x7F.
- run = 0 with 5 ticks -> pos unchanged, no step_pulse. run = 1 then 1 tick -> pos advances by one.
- At pos 0, write wr_addr = 1, wr_char = 23 in the same cycle as a tick -> tick discarded, pos = 0; HEX4 = 0x3F two edges after the write. Assert reset while in DWELL -> pos = 0, DEFAULT_MSG restored.
